// File: rtl/sum_accumulator_pkg.sv
// rtl/sum_accumulator_pkg.sv - shared types and constants for the block accumulator
package sum_accumulator_pkg;

   // Width of one adder-stage result: {cout, sum[7:0]}
   localparam int SAMPLE_W = 9;

   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   // Ceiling log2, usable in parameter expressions
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sum_accumulator_if.sv
// rtl/sum_accumulator_if.sv - sample input and block result handshake bundle
interface sum_accumulator_if
   import sum_accumulator_pkg::*;
#(
   parameter int N_SAMPLES = 16
);
   localparam int LOG2_N = clog2(N_SAMPLES);
   localparam int ACC_W  = SAMPLE_W + LOG2_N;

   logic                clear;
   logic                in_valid;
   logic                in_ready;
   logic [7:0]          in_sum;
   logic                in_cout;
   logic                out_valid;
   logic                out_ready;
   logic [ACC_W-1:0]    out_total;
   logic [SAMPLE_W-1:0] out_mean;
   logic [7:0]          out_count;

   // Producer/consumer side (drives samples, takes results)
   modport master (
      output clear, in_valid, in_sum, in_cout, out_ready,
      input  in_ready, out_valid, out_total, out_mean, out_count
   );

   // Accumulator side
   modport slave (
      input  clear, in_valid, in_sum, in_cout, out_ready,
      output in_ready, out_valid, out_total, out_mean, out_count
   );

endinterface

// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - accumulates N adder results into block total and mean
module sum_accumulator
   import sum_accumulator_pkg::*;
#(
   parameter int N_SAMPLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   sum_accumulator_if.slave   bus
);

   localparam int LOG2_N = clog2(N_SAMPLES);
   localparam int ACC_W  = SAMPLE_W + LOG2_N;
   localparam logic [LOG2_N-1:0] IDX_LAST = LOG2_N'(N_SAMPLES - 1);

   state_t              state_q;
   state_t              state_d;
   logic [ACC_W-1:0]    acc_q;
   logic [LOG2_N-1:0]   idx_q;
   logic [SAMPLE_W-1:0] sample;
   logic [ACC_W-1:0]    acc_sum;
   logic                accept;
   logic                last;

   assign sample  = {bus.in_cout, bus.in_sum};
   assign acc_sum = acc_q + ACC_W'(sample);
   assign accept  = bus.in_valid && (state_q == ACCUM);
   assign last    = (idx_q == IDX_LAST);

   // Handshake flags come from registered state only
   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == HOLD);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: clear wins, Nth accept enters HOLD, output handshake leaves it
   always_comb begin
      state_d = state_q;
      if (bus.clear) begin
         state_d = ACCUM;
      end else begin
         case (state_q)
            ACCUM:   if (accept && last) state_d = HOLD;
            HOLD:    if (bus.out_ready)  state_d = ACCUM;
            default: state_d = ACCUM;
         endcase
      end
   end

   // Datapath: running sum, sample index, and held block results
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q         <= '0;
         idx_q         <= '0;
         bus.out_total <= '0;
         bus.out_mean  <= '0;
         bus.out_count <= '0;
      end else if (bus.clear) begin
         acc_q <= '0;
         idx_q <= '0;
      end else if (accept) begin
         if (last) begin
            bus.out_total <= acc_sum;
            bus.out_mean  <= acc_sum[ACC_W-1 -: SAMPLE_W];
            bus.out_count <= bus.out_count + 8'd1;
            acc_q         <= '0;
            idx_q         <= '0;
         end else begin
            acc_q <= acc_sum;
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer of the 8-bit registered adder stage. Takes each `{cout, sum}` result as an unsigned 9-bit sample over a valid/ready handshake and accumulates a block of `N_SAMPLES` samples. It then presents the block total and truncated mean on an output valid/ready port. It converts the adder's per-cycle results into block statistics for the next processing stage.

## Interface
- `N_SAMPLES`, 16: samples per block; power of two, range 2..256.
- `LOG2_N`, local, = clog2(`N_SAMPLES`).
- `ACC_W`, local, = 9 + `LOG2_N`: total width, overflow-free by construction.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `clear` input 1: synchronous block abort/restart.
- `in_valid` input 1: sample present.
- `in_ready` output 1: block accepts a sample this cycle.
- `in_sum` input 8: adder `sum`.
- `in_cout` input 1: adder `cout`; sample = {`in_cout`, `in_sum`}.
- `out_valid` output 1: result held.
- `out_ready` input 1: consumer takes the result.
- `out_total` output `ACC_W`: sum of the block's samples.
- `out_mean` output 9: `out_total` >> `LOG2_N`, truncated.
- `out_count` output 8: number of completed blocks, mod 256.

## Operation
- FSM states:
  - ACCUM: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- Accept event: `in_valid` && `in_ready` at a rising edge.
- In ACCUM, each accept adds the zero-extended 9-bit sample to `acc` and increments `idx`.
- On the accept that makes `idx` reach `N_SAMPLES`-1 (the Nth sample):
  - `out_total` loads `acc` + sample, and `out_mean` loads the same value shifted.
  - `acc` and `idx` go to 0; `out_count` increments; state goes to HOLD.
- In HOLD:
  - `out_total` and `out_mean` stay stable, and inputs are ignored.
  - `out_valid` && `out_ready` returns the FSM to ACCUM.
- `clear` has highest priority at the edge:
  - `acc`, `idx` go to 0 and the state goes to ACCUM, so `out_valid` drops.
  - `out_total`, `out_mean` and `out_count` are retained, and any coincident input or output handshake is discarded.
- Arithmetic is unsigned. `acc` never wraps because `ACC_W` covers 511·`N_SAMPLES`. `out_count` wraps 255 → 0.
- Reset values: state ACCUM, `acc`=0, `idx`=0; outputs `out_valid`=0, `in_ready`=1, `out_total`=0, `out_mean`=0, `out_count`=0.
- A reset assertion mid-block or in HOLD discards all partial and held results immediately, independent of `clk`.

## Timing
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: `out_valid` rises in the cycle after the edge that accepts the Nth sample. `out_total` and `out_mean` are valid in that same cycle.
- Minimum block period is `N_SAMPLES`+1 cycles: N accepts plus one HOLD cycle with `out_ready` held high.
- When `in_valid` stalls, the partial `acc` is held with no timeout.
- `out_ready` asserted while `out_valid`=0 has no effect.
- After the output handshake, `in_ready` is 1 in the next cycle.
- Reset release: the first accept is possible at the first rising edge after `rst_n` goes high.

## Structure
- Package `sum_accumulator_pkg` holds:
  - the FSM state enum (ACCUM, HOLD);
  - the `clog2` function;
  - the constant 9 for the sample width (`SAMPLE_W`), shared with the adder stage's output width.
- Flat single module; the FSM and datapath are too small to justify a sub-module.
- Estimated 150–220 lines of RTL.

## Test plan
- Reset, then 4 samples with `N_SAMPLES`=4, `out_ready`=1. Samples are cout=0 with sums 10, 20, 30, 40.
  - Required: `out_total`=100, `out_mean`=25, `out_count`=1, `out_valid` high for exactly 1 cycle, 1 cycle after the 4th accept.
- Maximum input: 4× {cout=1, sum=8'hFF}.
  - Required: `out_total`=2044 (0x7FC), `out_mean`=511, no wrap.
- Backpressure: `out_ready`=0 for 5 cycles after the block completes, with `in_valid` held high.
  - Required: `in_ready`=0 throughout, outputs stable, no samples consumed.
  - After `out_ready`=1, the next block starts with `acc`=0.
- Intermittent `in_valid` (1,0,0,1,0,1,1) with sums 1, 2, 3, 4.
  - Required: `out_total`=10; stalled cycles add nothing.
- `clear` after 2 of 4 samples, then 4 samples of 5.
  - Required: `out_total`=20, `out_count` advances by 1 only.
  - `clear` asserted in HOLD drops `out_valid` next cycle and retains `out_total`.
- Asynchronous reset asserted mid-block, between edges.
  - Required: all outputs reach reset values immediately.
  - Then 256 blocks are run to confirm the `out_count` wrap to 0.
